// File: rtl/sfx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sfx_pkg
// Description : Shared types and defaults for the sound-effect arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sfx_pkg;

   localparam int SAMPLE_W_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      PLAY   = 2'd2,
      GAP    = 2'd3
   } sfx_state_t;

   typedef logic signed [SAMPLE_W_DEFAULT-1:0] sample_t;

endpackage
`default_nettype wire

// File: rtl/sfx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sfx_arbiter_if
// Description : Trigger, generator handshake and DAC sample bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface sfx_arbiter_if #(
   parameter int NUM_SFX  = 4,
   parameter int SAMPLE_W = 16,
   localparam int IDX_W   = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1
);
   logic                         sample_tick;
   logic [NUM_SFX-1:0]           trigger;
   logic [NUM_SFX-1:0]           sfx_busy;
   logic [NUM_SFX*SAMPLE_W-1:0]  sfx_left;
   logic [NUM_SFX*SAMPLE_W-1:0]  sfx_right;
   logic [NUM_SFX-1:0]           sfx_go;
   logic [NUM_SFX-1:0]           sfx_stop;
   logic [SAMPLE_W-1:0]          dac_left;
   logic [SAMPLE_W-1:0]          dac_right;
   logic                         active;
   logic [IDX_W-1:0]             active_id;
   logic [NUM_SFX-1:0]           pending;

   // Arbiter side
   modport master (
      input  sample_tick, trigger, sfx_busy, sfx_left, sfx_right,
      output sfx_go, sfx_stop, dac_left, dac_right, active, active_id, pending
   );

   // Trigger / generator / DAC side
   modport slave (
      output sample_tick, trigger, sfx_busy, sfx_left, sfx_right,
      input  sfx_go, sfx_stop, dac_left, dac_right, active, active_id, pending
   );
endinterface
`default_nettype wire

// File: rtl/sfx_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : sfx_prio_enc
// Description : Fixed-priority encoder, lowest set index wins.
// Revision    : 1.0 - initial release
// ============================================================================
module sfx_prio_enc #(
   parameter int N = 4,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  wire logic [N-1:0]     req,
   output logic      [IDX_W-1:0] idx,
   output logic                  valid
);

   // Scan downwards so the lowest set bit is the final assignment
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = IDX_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sfx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sfx_arbiter
// Description : Fixed-priority sound-effect arbiter sharing one DAC path.
// Revision    : 1.0 - initial release
// ============================================================================
module sfx_arbiter
   import sfx_pkg::*;
#(
   parameter int NUM_SFX        = 4,
   parameter int SAMPLE_W       = SAMPLE_W_DEFAULT,
   parameter bit PREEMPT        = 1'b1,
   parameter int LAUNCH_TIMEOUT = 1024,
   parameter int GAP_TICKS      = 2
) (
   input wire logic      clk,
   input wire logic      reset_n,
   sfx_arbiter_if.master bus
);

   localparam int c_IDX_W = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1;
   localparam int c_TO_W  = $clog2(LAUNCH_TIMEOUT + 1);
   localparam int c_GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
   localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(LAUNCH_TIMEOUT - 1);
   localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
   localparam logic [NUM_SFX-1:0] c_ONE      = NUM_SFX'(1);

   sfx_state_t           r_state;
   logic [NUM_SFX-1:0]   r_trig_q;
   logic [NUM_SFX-1:0]   r_pending;
   logic [NUM_SFX-1:0]   r_go;
   logic [NUM_SFX-1:0]   r_stop;
   logic [SAMPLE_W-1:0]  r_dac_left;
   logic [SAMPLE_W-1:0]  r_dac_right;
   logic                 r_active;
   logic [c_IDX_W-1:0]   r_active_id;
   logic [c_TO_W-1:0]    r_to_cnt;
   logic [c_GAP_W-1:0]   r_gap_cnt;

   logic [NUM_SFX-1:0]   w_rise;
   logic [c_IDX_W-1:0]   w_sel;
   logic                 w_sel_valid;
   logic [NUM_SFX-1:0]   w_sel_onehot;
   logic [NUM_SFX-1:0]   w_clr;
   logic [NUM_SFX-1:0]   w_below;
   logic                 w_preempt_valid;
   logic [c_IDX_W-1:0]   w_preempt_idx_unused;
   logic                 w_busy;
   logic [SAMPLE_W-1:0]  w_src_left;
   logic [SAMPLE_W-1:0]  w_src_right;

   assign w_rise       = bus.trigger & ~r_trig_q;
   assign w_sel_onehot = c_ONE << w_sel;
   assign w_clr        = (r_state == IDLE && w_sel_valid) ? w_sel_onehot : '0;
   // Requests strictly higher in priority than the granted source
   assign w_below      = r_pending & ((c_ONE << r_active_id) - c_ONE);
   assign w_busy       = bus.sfx_busy[r_active_id];
   assign w_src_left   = bus.sfx_left[int'(r_active_id) * SAMPLE_W +: SAMPLE_W];
   assign w_src_right  = bus.sfx_right[int'(r_active_id) * SAMPLE_W +: SAMPLE_W];

   sfx_prio_enc #(.N(NUM_SFX)) u_sel_enc (
      .req   (r_pending),
      .idx   (w_sel),
      .valid (w_sel_valid)
   );

   sfx_prio_enc #(.N(NUM_SFX)) u_preempt_enc (
      .req   (w_below),
      .idx   (w_preempt_idx_unused),
      .valid (w_preempt_valid)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_trig_q    <= bus.trigger;
         r_pending   <= '0;
         r_go        <= '0;
         r_stop      <= '0;
         r_dac_left  <= '0;
         r_dac_right <= '0;
         r_active    <= 1'b0;
         r_active_id <= '0;
         r_to_cnt    <= '0;
         r_gap_cnt   <= '0;
      end else begin
         r_trig_q  <= bus.trigger;
         // A new edge on a bit being launched this cycle survives the clear
         r_pending <= (r_pending & ~w_clr) | w_rise;
         r_go      <= '0;
         r_stop    <= '0;

         if (bus.sample_tick) begin
            r_dac_left  <= (r_state == PLAY) ? w_src_left  : '0;
            r_dac_right <= (r_state == PLAY) ? w_src_right : '0;
         end

         case (r_state)
            IDLE: begin
               if (w_sel_valid) begin
                  r_go        <= w_sel_onehot;
                  r_active_id <= w_sel;
                  r_active    <= 1'b1;
                  r_to_cnt    <= '0;
                  r_state     <= LAUNCH;
               end
            end
            LAUNCH: begin
               if (w_busy) begin
                  r_state <= PLAY;
               end else if (r_to_cnt == c_TO_LAST) begin
                  r_active  <= 1'b0;
                  r_gap_cnt <= '0;
                  r_state   <= GAP;
               end else begin
                  r_to_cnt <= r_to_cnt + c_TO_W'(1);
               end
            end
            PLAY: begin
               if (!w_busy) begin
                  r_active  <= 1'b0;
                  r_gap_cnt <= '0;
                  r_state   <= GAP;
               end else if (PREEMPT && w_preempt_valid) begin
                  r_stop    <= c_ONE << r_active_id;
                  r_active  <= 1'b0;
                  r_gap_cnt <= '0;
                  r_state   <= GAP;
               end
            end
            GAP: begin
               if (GAP_TICKS == 0) begin
                  r_state <= IDLE;
               end else if (bus.sample_tick) begin
                  if (r_gap_cnt == c_GAP_LAST) begin
                     r_gap_cnt <= '0;
                     r_state   <= IDLE;
                  end else begin
                     r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.sfx_go    = r_go;
   assign bus.sfx_stop  = r_stop;
   assign bus.dac_left  = r_dac_left;
   assign bus.dac_right = r_dac_right;
   assign bus.active    = r_active;
   assign bus.active_id = r_active_id;
   assign bus.pending   = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_sfx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sfx_arbiter
// Description : Directed self-checking bench for sfx_arbiter (with and without preemption).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sfx_arbiter;

   logic clk;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   sfx_arbiter_if #(.NUM_SFX(4), .SAMPLE_W(16)) bus ();
   sfx_arbiter_if #(.NUM_SFX(4), .SAMPLE_W(16)) bus_np ();

   sfx_arbiter #(.PREEMPT(1'b1)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   sfx_arbiter #(.PREEMPT(1'b0)) dut_np (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_np)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      bus.sample_tick = 1'b1;
      step();
      bus.sample_tick = 1'b0;
   endtask

   task automatic tick_np();
      bus_np.sample_tick = 1'b1;
      step();
      bus_np.sample_tick = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      bus.sample_tick = 1'b0; bus.trigger = '0; bus.sfx_busy = '0;
      bus.sfx_left = '0; bus.sfx_right = '0;
      bus_np.sample_tick = 1'b0; bus_np.trigger = '0; bus_np.sfx_busy = '0;
      bus_np.sfx_left = '0; bus_np.sfx_right = '0;
      repeat (3) step();

      // Reset state
      chk("rst_active", 32'(bus.active), 32'h0);
      chk("rst_pending", 32'(bus.pending), 32'h0);
      chk("rst_go", 32'(bus.sfx_go), 32'h0);
      chk("rst_stop", 32'(bus.sfx_stop), 32'h0);
      chk("rst_dac", 32'(bus.dac_left), 32'h0);
      chk("rst_id", 32'(bus.active_id), 32'h0);
      reset_n = 1'b1;
      step();

      // Single request on source 2
      bus.trigger = 4'b0100; step();
      chk("s1_pending", 32'(bus.pending), 32'h4);
      bus.trigger = 4'b0000; step();
      chk("s1_go", 32'(bus.sfx_go), 32'h4);
      chk("s1_active", 32'(bus.active), 32'h1);
      chk("s1_id", 32'(bus.active_id), 32'h2);
      chk("s1_pend_clr", 32'(bus.pending), 32'h0);
      bus.sfx_left[32 +: 16] = 16'h1234; bus.sfx_right[32 +: 16] = 16'hFEDC;
      bus.sfx_busy = 4'b0100; step();
      chk("s1_go_pulse", 32'(bus.sfx_go), 32'h0);
      chk("s1_dac_pre", 32'(bus.dac_left), 32'h0);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("s1_dac_l", 32'(bus.dac_left), 32'h1234);
         chk("s1_dac_r", 32'(bus.dac_right), 32'hFEDC);
         step(); step();
      end
      bus.sfx_busy = 4'b0000; step();
      chk("s1_gap_active", 32'(bus.active), 32'h0);
      chk("s1_gap_hold", 32'(bus.dac_left), 32'h1234);
      tick();
      chk("s1_gap_dac_l", 32'(bus.dac_left), 32'h0);
      chk("s1_gap_dac_r", 32'(bus.dac_right), 32'h0);
      tick(); step();
      chk("s1_idle_go", 32'(bus.sfx_go), 32'h0);
      chk("s1_idle_active", 32'(bus.active), 32'h0);

      // Simultaneous triggers 1 and 3
      bus.trigger = 4'b1010; step();
      bus.trigger = 4'b0000; step();
      chk("s2_go1", 32'(bus.sfx_go), 32'h2);
      chk("s2_id1", 32'(bus.active_id), 32'h1);
      chk("s2_pend", 32'(bus.pending), 32'h8);
      bus.sfx_left[16 +: 16] = 16'h0111; bus.sfx_right[16 +: 16] = 16'h8001;
      bus.sfx_busy = 4'b0010; step();
      tick();
      chk("s2_dac1", 32'(bus.dac_left), 32'h0111);
      bus.sfx_busy = 4'b0000; step();
      chk("s2_pend_gap", 32'(bus.pending), 32'h8);
      chk("s2_gap_active", 32'(bus.active), 32'h0);
      tick();
      chk("s2_gap_nogo", 32'(bus.sfx_go), 32'h0);
      tick(); step();
      chk("s2_go3", 32'(bus.sfx_go), 32'h8);
      chk("s2_id3", 32'(bus.active_id), 32'h3);
      chk("s2_pend_clr", 32'(bus.pending), 32'h0);

      // Preemption of source 3 by source 0
      bus.sfx_left[48 +: 16] = 16'h3333; bus.sfx_right[48 +: 16] = 16'hCCCC;
      bus.sfx_busy = 4'b1000; step();
      tick();
      chk("s3_dac3", 32'(bus.dac_left), 32'h3333);
      bus.trigger = 4'b0001; step();
      chk("s3_pend0", 32'(bus.pending), 32'h1);
      chk("s3_nostop", 32'(bus.sfx_stop), 32'h0);
      bus.trigger = 4'b0000; step();
      chk("s3_stop", 32'(bus.sfx_stop), 32'h8);
      chk("s3_stop_nogo", 32'(bus.sfx_go), 32'h0);
      chk("s3_active", 32'(bus.active), 32'h0);
      bus.sfx_busy = 4'b0000; step();
      chk("s3_stop_pulse", 32'(bus.sfx_stop), 32'h0);
      tick(); tick(); step();
      chk("s3_go0", 32'(bus.sfx_go), 32'h1);
      chk("s3_id0", 32'(bus.active_id), 32'h0);
      bus.sfx_busy = 4'b0001; step();
      bus.sfx_busy = 4'b0000; step();
      tick(); tick(); step();

      // Launch timeout on source 1
      bus.trigger = 4'b0010; step();
      bus.trigger = 4'b0000; step();
      chk("s4_go", 32'(bus.sfx_go), 32'h2);
      repeat (1022) step();
      tick();
      chk("s4_still_launch", 32'(bus.active), 32'h1);
      chk("s4_dac", 32'(bus.dac_left), 32'h0);
      step();
      chk("s4_timeout", 32'(bus.active), 32'h0);
      chk("s4_nostop", 32'(bus.sfx_stop), 32'h0);
      tick(); tick(); step();
      chk("s4_idle_go", 32'(bus.sfx_go), 32'h0);
      chk("s4_idle_active", 32'(bus.active), 32'h0);

      // Reset mid-PLAY with trigger[0] held
      bus.trigger = 4'b0001; step(); step();
      chk("s5_go", 32'(bus.sfx_go), 32'h1);
      bus.sfx_left[0 +: 16] = 16'h0A0A; bus.sfx_right[0 +: 16] = 16'hF5F5;
      bus.sfx_busy = 4'b0001; step();
      tick();
      chk("s5_dac", 32'(bus.dac_left), 32'h0A0A);
      reset_n = 1'b0; step();
      chk("s5_rst_active", 32'(bus.active), 32'h0);
      chk("s5_rst_dac_l", 32'(bus.dac_left), 32'h0);
      chk("s5_rst_dac_r", 32'(bus.dac_right), 32'h0);
      chk("s5_rst_go", 32'(bus.sfx_go), 32'h0);
      chk("s5_rst_pend", 32'(bus.pending), 32'h0);
      reset_n = 1'b1; bus.sfx_busy = 4'b0000;
      step(); step(); step();
      chk("s5_held_go", 32'(bus.sfx_go), 32'h0);
      chk("s5_held_pend", 32'(bus.pending), 32'h0);
      chk("s5_held_active", 32'(bus.active), 32'h0);
      bus.trigger = 4'b0000; step();
      bus.trigger = 4'b0001; step();
      chk("s5_retrig_pend", 32'(bus.pending), 32'h1);
      bus.trigger = 4'b0000; step();
      chk("s5_retrig_go", 32'(bus.sfx_go), 32'h1);
      bus.sfx_busy = 4'b0001; step();
      bus.sfx_busy = 4'b0000; step();
      tick(); tick(); step();

      // Re-trigger of the playing source replays it
      bus.trigger = 4'b0100; step();
      bus.trigger = 4'b0000; step();
      bus.sfx_busy = 4'b0100; step();
      bus.trigger = 4'b0100; step();
      chk("s6_pend", 32'(bus.pending), 32'h4);
      chk("s6_id", 32'(bus.active_id), 32'h2);
      chk("s6_nostop", 32'(bus.sfx_stop), 32'h0);
      bus.trigger = 4'b0000; bus.sfx_busy = 4'b0000; step();
      tick(); tick(); step();
      chk("s6_replay_go", 32'(bus.sfx_go), 32'h4);
      chk("s6_replay_pend", 32'(bus.pending), 32'h0);
      bus.sfx_busy = 4'b0100; step();
      bus.sfx_busy = 4'b0000; step();
      tick(); tick(); step();

      // No preemption: source 3 plays to completion
      bus_np.trigger = 4'b1000; step();
      bus_np.trigger = 4'b0000; step();
      chk("s7_go3", 32'(bus_np.sfx_go), 32'h8);
      bus_np.sfx_busy = 4'b1000; step();
      bus_np.trigger = 4'b0001; step();
      bus_np.trigger = 4'b0000; step(); step();
      chk("s7_nostop", 32'(bus_np.sfx_stop), 32'h0);
      chk("s7_active", 32'(bus_np.active), 32'h1);
      chk("s7_id", 32'(bus_np.active_id), 32'h3);
      chk("s7_pend", 32'(bus_np.pending), 32'h1);
      bus_np.sfx_busy = 4'b0000; step();
      chk("s7_gap", 32'(bus_np.active), 32'h0);
      tick_np(); tick_np(); step();
      chk("s7_go0", 32'(bus_np.sfx_go), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sfx_arbiter.md
Name: sfx_arbiter

Overview:
- Shares the single AUDIO_DAC sample path between NUM_SFX sound-effect generators (gun, explosion, …), each with a go/busy handshake like the shoot generator.
- Latches trigger requests, grants one generator at a time by fixed priority with optional preemption, and launches and retires it.
- Muxes the granted generator's 16-bit left/right samples to the DAC, updating once per audio frame.
- Sits between the key/game-logic triggers and AUDIO_DAC, in the CLOCK_50 domain.

Parameters:
- NUM_SFX, 4, number of requesters; index 0 is highest priority.
- SAMPLE_W, 16, sample width per channel.
- PREEMPT, 1, 1 = a higher-priority pending request aborts the current effect.
- LAUNCH_TIMEOUT, 1024, clk cycles to wait for busy to rise after go.
- GAP_TICKS, 2, silent sample_ticks inserted between effects.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset_n  in  1  synchronous active-low reset.
- sample_tick  in  1  one-cycle strobe per DAC LRCK frame, already synchronised to clk.
- trigger  in  NUM_SFX  level requests, rising-edge detected internally.
- sfx_busy  in  NUM_SFX  busy from each generator, synchronous to clk.
- sfx_left  in  NUM_SFX*SAMPLE_W  packed left samples; source i occupies bits [i*SAMPLE_W +: SAMPLE_W].
- sfx_right  in  NUM_SFX*SAMPLE_W  packed right samples, same packing.
- sfx_go  out  NUM_SFX  one-cycle launch pulse to the selected generator.
- sfx_stop  out  NUM_SFX  one-cycle abort pulse on preemption.
- dac_left  out  SAMPLE_W  sample to AUDIO_DAC left.
- dac_right  out  SAMPLE_W  sample to AUDIO_DAC right.
- active  out  1  an effect is in LAUNCH or PLAY.
- active_id  out  $clog2(NUM_SFX)  granted index; valid while active.
- pending  out  NUM_SFX  latched, not-yet-served requests (for LEDs).

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE; pending=0; sfx_go=0; sfx_stop=0; dac_left=0; dac_right=0; active=0; active_id=0; gap counter=0.
  - Edge-detect registers load the current trigger value, so a trigger held through reset does not fire.
  - Reset mid-effect abandons it without a stop pulse; generators are reset by the same reset_n.
- Request latch:
  - A rising edge on trigger[i] sets pending[i].
  - pending[i] clears in the cycle sfx_go[i] is issued.
  - Re-trigger of an already pending source has no further effect.
  - Re-trigger of the currently playing source sets pending again, so the effect replays after it finishes.
  - A set and a clear of the same bit in one cycle: the set wins.
- Selection: sel = lowest set index of pending, via a combinational priority encoder.
- States:
  - IDLE:
    - pending!=0 -> LAUNCH.
    - In that same cycle: sfx_go[sel]=1, active_id<=sel, active=1.
  - LAUNCH:
    - sfx_busy[active_id]=1 -> PLAY.
    - LAUNCH_TIMEOUT cycles elapse without busy -> GAP (effect dropped, no stop pulse).
  - PLAY:
    - On each sample_tick, dac_left/right <= sfx_left/right[active_id].
    - sfx_busy[active_id] falls -> GAP.
    - If PREEMPT=1 and pending has a set bit below active_id: sfx_stop[active_id]=1 for one cycle, then -> GAP.
    - Busy falling takes precedence over preemption in the same cycle.
  - GAP:
    - active=0; dac outputs <= 0 on each sample_tick.
    - Count GAP_TICKS sample_ticks, then -> IDLE.
    - With GAP_TICKS=0, go to IDLE the next cycle.
- DAC output:
  - Changes only on sample_tick, one cycle after the tick (registered), so AUDIO_DAC sees a stable word for a whole frame.
  - Outside PLAY, the output is 0 (two's-complement silence).
- sfx_go and sfx_stop are one-hot or zero, and never both asserted in one cycle.
- Busy inputs of non-granted sources are ignored.

Decomposition:
- Package sfx_pkg holds:
  - typedef enum {IDLE, LAUNCH, PLAY, GAP} sfx_state_t;
  - localparam SAMPLE_W_DEFAULT=16;
  - the sample_t typedef (logic signed [15:0]).
- One sub-module, sfx_prio_enc (parameter N): input req[N], outputs idx and valid. It is used for selection and for the preemption check (the masked request vector is computed as req & ((1<<active_id)-1)).

Test Plan:
- Single request: after reset, pulse trigger[2]; hold sfx_busy[2]=1 for 10 ticks with left=16'h1234, right=16'hFEDC -> sfx_go[2] one cycle; dac=1234/FEDC one cycle after each tick; dac=0 for 2 ticks after busy falls; active=0.
- Simultaneous triggers 1 and 3 in the same cycle -> source 1 launched first; source 3 launched after source 1's busy falls plus 2 gap ticks; pending shows 4'b1000 meanwhile.
- Preemption (PREEMPT=1): source 3 playing, trigger[0] -> sfx_stop[3] one cycle, GAP, then sfx_go[0]. With PREEMPT=0 -> source 3 plays to completion first.
- Launch timeout: trigger[1], busy never rises -> returns to IDLE after 1024 cycles plus the gap; dac stays 0; no stop pulse.
- Reset mid-PLAY: assert reset_n=0 for one cycle with trigger[0] held high -> all outputs 0; no go after reset until trigger[0] toggles low then high.
- Re-trigger while playing source 2 -> pending[2]=1; source 2 replays once after the gap.
